mux_rr_scheduler: RTL and testbench

//  Round-robin scheduler that shares the pipelined 64:1 byte mux tree among NUM_REQ requesters.

---
 rtl/mux_rr_scheduler.sv | 174 +++++++++++++++++
 tb/tb_mux_rr_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing a pipelined byte mux tree among NUM_REQ requesters.
// Issues at most one selection per cycle, tracks it through the mux latency with a tag
// pipe, and captures the mux result into a credit-protected show-ahead output FIFO.
module mux_rr_scheduler #(
    parameter int unsigned NUM_REQ    = 64,
    parameter int unsigned SEL_W      = 6,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MUX_LAT    = 6,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   mux_sel,
    input  logic [DATA_W-1:0]  mux_dout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [SEL_W-1:0]   out_src,
    output logic               busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  src;
    } fifo_ent_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_rr_ptr;
    logic [MUX_LAT-1:0] r_pipe_vld;
    logic [SEL_W-1:0]   r_pipe_idx [MUX_LAT];
    logic [CNT_W-1:0]   r_inflight;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    fifo_ent_t          r_mem [FIFO_DEPTH];

    logic               w_found;
    logic [SEL_W-1:0]   w_pick;
    logic [SEL_W-1:0]   w_scan_idx;
    logic               w_has_credit;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;

    // Credit: buffered plus in-flight results must leave room for one more issue
    assign w_has_credit = (OCC_W'(r_count) + OCC_W'(r_inflight)) < OCC_W'(FIFO_DEPTH);
    assign w_issue      = (r_state == ST_RUN) && w_found && w_has_credit;
    assign w_push       = r_pipe_vld[MUX_LAT-1];
    assign w_pop        = out_valid && out_ready;

    // Round-robin scan: first requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        w_found    = 1'b0;
        w_pick     = '0;
        w_scan_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_scan_idx = r_rr_ptr + SEL_W'(i);
            if (!w_found && req[w_scan_idx]) begin
                w_found = 1'b1;
                w_pick  = w_scan_idx;
            end
        end
    end

    // Issue strobe and mux select; both idle at zero when nothing issues
    always_comb begin
        grant   = '0;
        mux_sel = '0;
        if (w_issue) begin
            grant[w_pick] = 1'b1;
            mux_sel       = w_pick;
        end
    end

    // FSM next state; enable takes priority so DRAIN can resume issuing directly
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (enable) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) w_state_nxt = (r_inflight != '0) ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (enable)                 w_state_nxt = ST_RUN;
                else if (r_inflight == '0)  w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Round-robin pointer advances past the granted requester, holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_rr_ptr <= '0;
        else if (w_issue) r_rr_ptr <= w_pick + SEL_W'(1);
    end

    // Tag pipe mirrors the mux tree latency so each result is paired with its source
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < int'(MUX_LAT); i++) r_pipe_idx[i] <= '0;
        end else begin
            r_pipe_vld[0] <= w_issue;
            r_pipe_idx[0] <= mux_sel;
            for (int i = 1; i < int'(MUX_LAT); i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_idx[i] <= r_pipe_idx[i-1];
            end
        end
    end

    // In-flight counter: issues enter, pushes leave
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            unique case ({w_issue, w_push})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Output FIFO storage, pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
        end else begin
            assert (!(w_push && (r_count == CNT_W'(FIFO_DEPTH))));
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{data: mux_dout, src: r_pipe_idx[MUX_LAT-1]};
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rd_ptr].data;
    assign out_src   = r_mem[r_rd_ptr].src;
    assign busy      = (r_state != ST_IDLE) || out_valid;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Self-checking bench for mux_rr_scheduler: directed phases plus randomized traffic,
// compared every cycle against a queue-based behavioural model.
module tb_mux_rr_scheduler;

    localparam int NR  = 64;
    localparam int SW  = 6;
    localparam int DW  = 8;
    localparam int LAT = 6;
    localparam int DEP = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] grant;
    logic [SW-1:0] mux_sel;
    logic [DW-1:0] mux_dout;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [SW-1:0] out_src;
    logic          busy;

    always #5 clk = ~clk;

    mux_rr_scheduler #(
        .NUM_REQ(NR), .SEL_W(SW), .DATA_W(DW), .MUX_LAT(LAT), .FIFO_DEPTH(DEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .grant(grant),
        .mux_sel(mux_sel), .mux_dout(mux_dout), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_src(out_src), .busy(busy)
    );

    // Mux tree model: returns 8'hA0 + the index selected LAT cycles earlier
    logic [SW-1:0] hist [LAT];
    always @(posedge clk) begin
        hist[0] <= mux_sel;
        for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
    end
    assign mux_dout = 8'hA0 + {2'b00, hist[LAT-1]};

    int tests = 0;
    int fails = 0;

    // Reference model state
    int            m_state;   // 0 idle, 1 run, 2 drain
    int            m_rr;
    logic [DW-1:0] mq_data [$];
    logic [SW-1:0] mq_src [$];
    int            fl_cyc [$];
    int            fl_idx [$];
    int            cyc;
    bit            e_issue;
    int            e_k;
    logic [NR-1:0] e_grant;

    // Stimulus controls and observation counters
    logic [NR-1:0] mask = '0;
    bit            renew_all = 1'b1;
    bit            rand_ready = 1'b0;
    bit            rand_en = 1'b0;
    int            g_cnt = 0;
    int            g_first = -1;
    int            p_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int first_req(input logic [NR-1:0] r, input int ptr);
        for (int i = 0; i < NR; i++) begin
            int j;
            j = (ptr + i) % NR;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_state = 0;
        m_rr    = 0;
        mq_data.delete();
        mq_src.delete();
        fl_cyc.delete();
        fl_idx.delete();
        e_issue = 1'b0;
        e_grant = '0;
    endtask

    task automatic eval_check();
        int            credit;
        logic [SW-1:0] es;
        credit  = DEP - mq_src.size() - fl_idx.size();
        e_k     = first_req(req, m_rr);
        e_issue = (m_state == 1) && (e_k >= 0) && (credit > 0);
        e_grant = '0;
        es      = '0;
        if (e_issue) begin
            e_grant[e_k] = 1'b1;
            es = SW'(e_k);
        end
        chk("grant", 64'(grant), 64'(e_grant));
        chk("mux_sel", 64'(mux_sel), 64'(es));
        chk("out_valid", 64'(out_valid), 64'(mq_src.size() > 0));
        chk("busy", 64'(busy), 64'((m_state != 0) || (mq_src.size() > 0)));
        if (mq_src.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(mq_data[0]));
            chk("out_src", 64'(out_src), 64'(mq_src[0]));
        end
        if (!rst_n) begin
            chk("rst_out_data", 64'(out_data), 64'd0);
            chk("rst_out_src", 64'(out_src), 64'd0);
        end
        if (grant != '0) begin
            g_cnt++;
            if (g_first < 0) g_first = int'(mux_sel);
        end
        if (out_valid && out_ready) p_cnt++;
    endtask

    task automatic model_update();
        int n_in;
        n_in = fl_idx.size();
        if (mq_src.size() > 0 && out_ready) begin
            void'(mq_src.pop_front());
            void'(mq_data.pop_front());
        end
        if (n_in > 0 && fl_cyc[0] + LAT == cyc) begin
            mq_data.push_back(DW'(8'hA0 + fl_idx[0]));
            mq_src.push_back(SW'(fl_idx[0]));
            void'(fl_cyc.pop_front());
            void'(fl_idx.pop_front());
        end
        if (e_issue) begin
            fl_cyc.push_back(cyc);
            fl_idx.push_back(e_k);
            m_rr = (e_k + 1) % NR;
        end
        case (m_state)
            0: if (enable) m_state = 1;
            1: if (!enable) m_state = (n_in > 0) ? 2 : 0;
            default: begin
                if (enable)         m_state = 1;
                else if (n_in == 0) m_state = 0;
            end
        endcase
        cyc++;
    endtask

    task automatic drive_next();
        logic [NR-1:0] rn;
        rn  = renew_all ? {NR{1'b1}} : ({$urandom, $urandom} & {$urandom, $urandom});
        req = (req & ~e_grant) | (mask & rn);
        if (rand_ready) out_ready = ($urandom_range(0, 1) != 0);
        if (rand_en)    enable    = ($urandom_range(0, 15) != 0);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            eval_check();
            @(posedge clk);
            if (rst_n) model_update();
            #1;
            drive_next();
        end
    endtask

    task automatic go_idle();
        int n;
        n          = 0;
        enable     = 1'b0;
        req        = '0;
        mask       = '0;
        out_ready  = 1'b1;
        rand_ready = 1'b0;
        rand_en    = 1'b0;
        renew_all  = 1'b1;
        while ((m_state != 0 || mq_src.size() > 0 || fl_idx.size() > 0) && n < 60) begin
            run(1);
            n++;
        end
        chk("idle_bound", 64'(n < 60), 64'd1);
    endtask

    initial begin
        cyc = 0;
        m_reset();

        // Reset state
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;

        // All requesting: sequential grants 0..63 and wrap to 0
        enable = 1'b1;
        mask   = '1;
        req    = '1;
        run(72);

        // Two requesters: alternating grants with pointer wrap
        go_idle();
        mask    = '0;
        mask[5] = 1'b1;
        mask[9] = 1'b1;
        req     = mask;
        enable  = 1'b1;
        run(20);

        // Backpressure: exactly FIFO_DEPTH grants, then resume one per pop
        go_idle();
        g_cnt     = 0;
        out_ready = 1'b0;
        enable    = 1'b1;
        mask      = '1;
        req       = '1;
        run(20);
        chk("bp_grants", 64'(g_cnt), 64'(DEP));
        out_ready = 1'b1;
        run(30);

        // Randomized traffic with random enable and backpressure
        go_idle();
        renew_all  = 1'b0;
        rand_ready = 1'b1;
        rand_en    = 1'b1;
        enable     = 1'b1;
        for (int p = 0; p < 4; p++) begin
            mask = {$urandom, $urandom};
            if (p == 3) mask = mask & {$urandom, $urandom} & {$urandom, $urandom};
            run(100);
        end

        // Drain: three issued, enable dropped, all three delivered
        go_idle();
        g_cnt  = 0;
        p_cnt  = 0;
        enable = 1'b1;
        mask   = '1;
        req    = '1;
        run(3);
        enable = 1'b0;
        run(1);
        mask = '0;
        req  = '0;
        go_idle();
        chk("drain_grants", 64'(g_cnt), 64'd3);
        chk("drain_pops", 64'(p_cnt), 64'd3);

        // Mid-stream reset discards everything; first grant after release is index 0
        enable = 1'b1;
        mask   = '1;
        req    = '1;
        run(12);
        rst_n = 1'b0;
        m_reset();
        run(2);
        rst_n   = 1'b1;
        g_first = -1;
        run(4);
        chk("post_rst_first_grant", 64'(g_first), 64'd0);
        run(LAT + 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
